// File: rtl/my_cpu_pkg.sv
// Shared definitions for the execute sequencer: instruction field layout,
// the ALU opclass code, and the sequencer state encoding.
package my_cpu_pkg;

    localparam int DATA_W_DEF = 16;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int FN_HI  = 7;
    localparam int FN_LO  = 4;
    localparam int RB_HI  = 3;
    localparam int RB_LO  = 0;

    localparam logic [3:0] OPC_ALU = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/my_regfile.sv
// Register file with NREG x DATA_W entries, two operand read ports, one
// debug read port, and one synchronous write port. Reset clears every entry.
module my_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     ra_addr_i,
    input  logic [AW-1:0]     rb_addr_i,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    output logic [DATA_W-1:0] rb_data_o,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] mem_q [NREG];

    // NOTE: every entry must read as zero after reset, so the array is cleared
    // under reset; this forces flops rather than a RAM macro, which is fine at 16 entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o  = mem_q[ra_addr_i];
    assign rb_data_o  = mem_q[rb_addr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/my_alu_exec_seq.sv
// Four-cycle execute sequencer: accept, read operands, capture the ALU result,
// write back R[Rd] <= R[Rd] op R[Rb]. Preloads share the write port while idle.
module my_alu_exec_seq
    import my_cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [15:0]       IR_IN,
    input  logic              IR_VALID,
    output logic              IR_READY,
    output logic [15:0]       IR_Q,
    input  logic              IS_ALU,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    input  logic [DATA_W-1:0] ALU_R,
    input  logic              LD_EN,
    input  logic [3:0]        LD_ADDR,
    input  logic [DATA_W-1:0] LD_DATA,
    input  logic [3:0]        DBG_ADDR,
    output logic [DATA_W-1:0] DBG_DATA,
    output logic              DONE,
    output logic              ERR,
    output logic              BUSY
);

    state_e            state_q;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [DATA_W-1:0] result_q;
    logic              done_q;
    logic              err_q;

    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              wr_en_d;
    logic [3:0]        wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;

    // Write-port arbitration: preload only while idle, write-back only in WB.
    // The two never overlap, so no priority decision is needed.
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = LD_ADDR;
        wr_data_d = LD_DATA;
        if (state_q == ST_WB) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ir_q[RD_HI:RD_LO];
            wr_data_d = result_q;
        end else if (state_q == ST_IDLE && LD_EN) begin
            wr_en_d   = 1'b1;
        end
    end

    my_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk_i      (CLK),
        .rst_i      (RST),
        .we_i       (wr_en_d),
        .waddr_i    (wr_addr_d),
        .wdata_i    (wr_data_d),
        .ra_addr_i  (ir_q[RD_HI:RD_LO]),
        .rb_addr_i  (ir_q[RB_HI:RB_LO]),
        .dbg_addr_i (DBG_ADDR),
        .ra_data_o  (ra_data),
        .rb_data_o  (rb_data),
        .dbg_data_o (DBG_DATA)
    );

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (IR_VALID) begin
                        ir_q    <= IR_IN;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!IS_ALU) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        alu_a_q <= ra_data;
                        alu_b_q <= rb_data;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= ALU_R;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign IR_READY = (state_q == ST_IDLE);
    assign BUSY     = (state_q != ST_IDLE);
    assign IR_Q     = ir_q;
    assign ALU_A    = alu_a_q;
    assign ALU_B    = alu_b_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_my_alu_exec_seq.sv
// Directed bench for my_alu_exec_seq with a stub adder ALU and opclass decoder.
// Instruction layout: [15:12] opclass, [11:8] Rd, [7:4] fn, [3:0] Rb.
module tb_my_alu_exec_seq;
    import my_cpu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] IR_IN;
    logic        IR_VALID;
    logic        IR_READY;
    logic [15:0] IR_Q;
    logic        IS_ALU;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [15:0] ALU_R;
    logic        LD_EN;
    logic [3:0]  LD_ADDR;
    logic [15:0] LD_DATA;
    logic [3:0]  DBG_ADDR;
    logic [15:0] DBG_DATA;
    logic        DONE;
    logic        ERR;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    my_alu_exec_seq #(.DATA_W(16), .NREG(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IR_IN    (IR_IN),
        .IR_VALID (IR_VALID),
        .IR_READY (IR_READY),
        .IR_Q     (IR_Q),
        .IS_ALU   (IS_ALU),
        .ALU_A    (ALU_A),
        .ALU_B    (ALU_B),
        .ALU_R    (ALU_R),
        .LD_EN    (LD_EN),
        .LD_ADDR  (LD_ADDR),
        .LD_DATA  (LD_DATA),
        .DBG_ADDR (DBG_ADDR),
        .DBG_DATA (DBG_DATA),
        .DONE     (DONE),
        .ERR      (ERR),
        .BUSY     (BUSY)
    );

    // Stub ALU and decoder
    assign ALU_R  = ALU_A + ALU_B;
    assign IS_ALU = (IR_Q[OPC_HI:OPC_LO] == OPC_ALU);

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] addr, input logic [15:0] expected);
        DBG_ADDR = addr;
        #1;
        check(tag, {16'h0, DBG_DATA}, {16'h0, expected});
    endtask

    task automatic load(input logic [3:0] addr, input logic [15:0] data);
        LD_EN   = 1'b1;
        LD_ADDR = addr;
        LD_DATA = data;
        tick();
        LD_EN   = 1'b0;
    endtask

    initial begin
        RST = 1'b1; IR_IN = '0; IR_VALID = 1'b0;
        LD_EN = 1'b0; LD_ADDR = '0; LD_DATA = '0; DBG_ADDR = '0;
        tick();
        tick();
        RST = 1'b0;
        #1;

        // Reset state
        check("rst_ready", {31'h0, IR_READY}, 32'd1);
        check("rst_busy",  {31'h0, BUSY},     32'd0);
        check("rst_done",  {31'h0, DONE},     32'd0);
        check("rst_err",   {31'h0, ERR},      32'd0);
        check("rst_irq",   {16'h0, IR_Q},     32'h0);
        check("rst_alu_a", {16'h0, ALU_A},    32'h0);
        check("rst_alu_b", {16'h0, ALU_B},    32'h0);
        for (int i = 0; i < 16; i++) begin
            check_reg($sformatf("rst_r%0d", i), 4'(i), 16'h0);
        end

        // Preload, then R1 = R1 + R2 with wrap-around
        load(4'd1, 16'hFF00);
        load(4'd2, 16'h0101);
        check_reg("pre_r1", 4'd1, 16'hFF00);
        check_reg("pre_r2", 4'd2, 16'h0101);

        IR_IN = 16'h01A2; IR_VALID = 1'b1;
        tick();                                  // accept edge
        IR_VALID = 1'b0;
        check("i1_ready_c0", {31'h0, IR_READY}, 32'd0);
        check("i1_busy_c0",  {31'h0, BUSY},     32'd1);
        check("i1_irq",      {16'h0, IR_Q},     32'h01A2);
        tick();                                  // READ edge
        check("i1_ready_c1", {31'h0, IR_READY}, 32'd0);
        check("i1_alu_a",    {16'h0, ALU_A},    32'hFF00);
        check("i1_alu_b",    {16'h0, ALU_B},    32'h0101);
        tick();                                  // EXEC edge
        check("i1_ready_c2", {31'h0, IR_READY}, 32'd0);
        check("i1_done_c2",  {31'h0, DONE},     32'd0);
        tick();                                  // WB edge
        check("i1_done_c3",  {31'h0, DONE},     32'd1);
        check("i1_ready_c3", {31'h0, IR_READY}, 32'd1);
        check("i1_busy_c3",  {31'h0, BUSY},     32'd0);
        check_reg("i1_r1", 4'd1, 16'h0001);
        check_reg("i1_r2", 4'd2, 16'h0101);
        tick();
        check("i1_done_off", {31'h0, DONE}, 32'd0);

        // Non-ALU opclass is rejected
        IR_IN = 16'h11A2; IR_VALID = 1'b1;
        tick();
        IR_VALID = 1'b0;
        check("e_ready_c0", {31'h0, IR_READY}, 32'd0);
        tick();
        check("e_err",      {31'h0, ERR},      32'd1);
        check("e_done",     {31'h0, DONE},     32'd0);
        check("e_ready",    {31'h0, IR_READY}, 32'd1);
        check("e_alu_hold", {16'h0, ALU_A},    32'hFF00);
        tick();
        check("e_err_off",  {31'h0, ERR},      32'd0);
        check("e_done_off", {31'h0, DONE},     32'd0);
        check_reg("e_r1", 4'd1, 16'h0001);

        // Rd == Rb: R3 = R3 + R3
        load(4'd3, 16'd16);
        IR_IN = 16'h0303; IR_VALID = 1'b1;
        tick();
        IR_VALID = 1'b0;
        tick();
        check("rr_alu_a", {16'h0, ALU_A}, 32'd16);
        check("rr_alu_b", {16'h0, ALU_B}, 32'd16);
        tick();
        tick();
        check("rr_done", {31'h0, DONE}, 32'd1);
        check_reg("rr_r3", 4'd3, 16'd32);

        // Preload strobe during EXEC is ignored
        IR_IN = 16'h01A2; IR_VALID = 1'b1;
        tick();
        IR_VALID = 1'b0;
        tick();                                  // now in EXEC
        LD_EN = 1'b1; LD_ADDR = 4'd4; LD_DATA = 16'hAAAA;
        tick();
        LD_EN = 1'b0;
        tick();
        check("ld_done", {31'h0, DONE}, 32'd1);
        check_reg("ld_r4", 4'd4, 16'h0000);
        check_reg("ld_r1", 4'd1, 16'h0102);

        // Reset during EXEC aborts
        IR_IN = 16'h0E12; IR_VALID = 1'b1;
        tick();
        IR_VALID = 1'b0;
        tick();                                  // now in EXEC
        RST = 1'b1;
        #1;
        check("ab_busy",  {31'h0, BUSY},     32'd0);
        check("ab_ready", {31'h0, IR_READY}, 32'd1);
        check("ab_irq",   {16'h0, IR_Q},     32'h0);
        check("ab_alu_a", {16'h0, ALU_A},    32'h0);
        tick();
        RST = 1'b0;
        tick();
        check("ab_done", {31'h0, DONE}, 32'd0);
        tick();
        check("ab_done2", {31'h0, DONE}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check_reg($sformatf("ab_r%0d", i), 4'(i), 16'h0);
        end

        // Back-to-back with IR_VALID held high
        load(4'd1, 16'd5);
        load(4'd2, 16'd7);
        IR_IN = 16'h01A2; IR_VALID = 1'b1;
        tick();                                  // edge 0: first accepted
        IR_IN = 16'h0152;
        check("bb_irq0", {16'h0, IR_Q}, 32'h01A2);
        tick();
        tick();
        tick();                                  // edge 3: first write-back
        check("bb_done1",  {31'h0, DONE}, 32'd1);
        check("bb_irq3",   {16'h0, IR_Q}, 32'h01A2);
        check_reg("bb_r1a", 4'd1, 16'd12);
        tick();                                  // edge 4: second accepted
        IR_VALID = 1'b0;
        check("bb_irq4",   {16'h0, IR_Q},     32'h0152);
        check("bb_ready4", {31'h0, IR_READY}, 32'd0);
        check("bb_done4",  {31'h0, DONE},     32'd0);
        tick();
        check("bb_alu_a2", {16'h0, ALU_A}, 32'd12);
        tick();
        tick();                                  // edge 7: second write-back
        check("bb_done2", {31'h0, DONE}, 32'd1);
        check_reg("bb_r1b", 4'd1, 16'd19);
        check_reg("bb_r2",  4'd2, 16'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
